// File: rtl/cp0_exception_controller.sv
// ---------------------------------------------------------------------------
// cp0_exception_controller
//
// Purpose:
//   Holds the CP0 register set (BadVAddr, Count, Compare, Status, Cause, EPC)
//   for the 5-stage MIPS core. It sequences precise exceptions and ERET from
//   the write-back stage's CP0 commit, and serves MFC0 reads. It also raises a
//   registered one-cycle pipeline flush with its redirect target, and an
//   interrupt-pending flag that decode tags onto the next instruction.
//
// Ports:
//   clock, reset_n        core clock, synchronous active-low reset
//   cp0_write_enabled     MTC0 commit from WB
//   cp0_address_register  MTC0/MFC0 register number (rd)
//   cp0_address_select    MTC0/MFC0 select (sel)
//   cp0_write_data        MTC0 data
//   exception_valid       WB commits an exception (interrupts use code 0)
//   eret_flush            WB commits ERET
//   in_delay_slot         faulting instruction sits in a branch delay slot
//   exception_code        ExcCode of the committed exception
//   exception_address     PC of the faulting instruction
//   is_address_fault      BadVAddr is loaded with badvaddr_value
//   badvaddr_value        faulting virtual address
//   read_data             MFC0 data, combinational (no write bypass)
//   hardware_interrupt    external interrupt lines, level sensitive
//   interrupt_pending     IE & ~EXL & |(Cause.IP & Status.IM), combinational
//   flush_valid           one-cycle flush pulse, registered
//   flush_target          redirect PC, valid with flush_valid
// ---------------------------------------------------------------------------
module cp0_exception_controller #(
    parameter logic [31:0] EXCEPTION_VECTOR = 32'hBFC0_0380,
    parameter logic        STATUS_BEV_RESET = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cp0_write_enabled,
    input  logic [4:0]  cp0_address_register,
    input  logic [2:0]  cp0_address_select,
    input  logic [31:0] cp0_write_data,
    input  logic        exception_valid,
    input  logic        eret_flush,
    input  logic        in_delay_slot,
    input  logic [4:0]  exception_code,
    input  logic [31:0] exception_address,
    input  logic        is_address_fault,
    input  logic [31:0] badvaddr_value,
    output logic [31:0] read_data,
    input  logic [5:0]  hardware_interrupt,
    output logic        interrupt_pending,
    output logic        flush_valid,
    output logic [31:0] flush_target
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    // Architectural state
    logic [31:0] r_badvaddr;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic [31:0] r_epc;
    logic [7:0]  r_status_im;
    logic        r_status_exl;
    logic        r_status_ie;
    logic        r_cause_bd;
    logic        r_cause_ti;
    logic [1:0]  r_cause_ip_sw;
    logic [4:0]  r_cause_exc;
    logic [5:0]  r_hw_sample;
    logic        r_tick;
    logic        r_flush_valid;
    logic [31:0] r_flush_target;

    logic        w_sel0;
    logic        w_mtc0;
    logic        w_wr_count;
    logic        w_wr_compare;
    logic        w_wr_status;
    logic        w_wr_cause;
    logic        w_wr_epc;
    logic        w_count_updated;
    logic [31:0] w_count_next;
    logic [7:0]  w_cause_ip;
    logic [31:0] w_status;
    logic [31:0] w_cause;

    // An MTC0 only takes effect when no exception or ERET commits in the same
    // cycle; a dropped write is simply lost.
    assign w_sel0       = (cp0_address_select == 3'd0);
    assign w_mtc0       = cp0_write_enabled & ~exception_valid & ~eret_flush & w_sel0;
    assign w_wr_count   = w_mtc0 & (cp0_address_register == REG_COUNT);
    assign w_wr_compare = w_mtc0 & (cp0_address_register == REG_COMPARE);
    assign w_wr_status  = w_mtc0 & (cp0_address_register == REG_STATUS);
    assign w_wr_cause   = w_mtc0 & (cp0_address_register == REG_CAUSE);
    assign w_wr_epc     = w_mtc0 & (cp0_address_register == REG_EPC);

    // Count moves at half the core clock; a software load restarts the phase.
    assign w_count_updated = w_wr_count | r_tick;
    assign w_count_next    = w_wr_count ? cp0_write_data :
                             (r_tick ? (r_count + 32'd1) : r_count);

    assign w_cause_ip = {r_hw_sample[5] | r_cause_ti, r_hw_sample[4:0], r_cause_ip_sw};

    assign w_status = {9'd0, STATUS_BEV_RESET, 6'd0, r_status_im, 6'd0,
                       r_status_exl, r_status_ie};
    assign w_cause  = {r_cause_bd, r_cause_ti, 14'd0, w_cause_ip, 1'b0,
                       r_cause_exc, 2'd0};

    assign interrupt_pending = r_status_ie & ~r_status_exl & (|(w_cause_ip & r_status_im));
    assign flush_valid       = r_flush_valid;
    assign flush_target      = r_flush_target;

    // MFC0 read mux: unmapped registers and non-zero selects read as zero.
    always_comb begin
        read_data = 32'd0;
        if (w_sel0) begin
            case (cp0_address_register)
                REG_BADVADDR: read_data = r_badvaddr;
                REG_COUNT:    read_data = r_count;
                REG_COMPARE:  read_data = r_compare;
                REG_STATUS:   read_data = w_status;
                REG_CAUSE:    read_data = w_cause;
                REG_EPC:      read_data = r_epc;
                default:      read_data = 32'd0;
            endcase
        end else begin
            read_data = 32'd0;
        end
    end

    // Timer: Count/tick/Compare and the timer interrupt flag.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_count    <= 32'd0;
            r_tick     <= 1'b0;
            r_compare  <= 32'd0;
            r_cause_ti <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_tick  <= w_wr_count ? 1'b0 : ~r_tick;
            if (w_wr_compare) begin
                r_compare <= cp0_write_data;
            end
            // A Compare write clears TI and beats a same-cycle match.
            if (w_wr_compare) begin
                r_cause_ti <= 1'b0;
            end else if (w_count_updated && (w_count_next == r_compare)) begin
                r_cause_ti <= 1'b1;
            end
        end
    end

    // External interrupt lines are sampled once per cycle into Cause.IP.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_hw_sample <= 6'd0;
        end else begin
            r_hw_sample <= hardware_interrupt;
        end
    end

    // Exception / ERET / MTC0 sequencing of Status, Cause, EPC and BadVAddr.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_status_im   <= 8'd0;
            r_status_exl  <= 1'b0;
            r_status_ie   <= 1'b0;
            r_cause_bd    <= 1'b0;
            r_cause_ip_sw <= 2'd0;
            r_cause_exc   <= 5'd0;
            r_epc         <= 32'd0;
            r_badvaddr    <= 32'd0;
        end else if (exception_valid) begin
            // Nested exceptions keep the original return address and BD.
            if (!r_status_exl) begin
                r_epc      <= in_delay_slot ? (exception_address - 32'd4) : exception_address;
                r_cause_bd <= in_delay_slot;
            end
            r_status_exl <= 1'b1;
            r_cause_exc  <= exception_code;
            if (is_address_fault) begin
                r_badvaddr <= badvaddr_value;
            end
        end else if (eret_flush) begin
            r_status_exl <= 1'b0;
        end else begin
            if (w_wr_status) begin
                r_status_im  <= cp0_write_data[15:8];
                r_status_exl <= cp0_write_data[1];
                r_status_ie  <= cp0_write_data[0];
            end
            if (w_wr_cause) begin
                r_cause_ip_sw <= cp0_write_data[9:8];
            end
            if (w_wr_epc) begin
                r_epc <= cp0_write_data;
            end
        end
    end

    // Flush pulse: one cycle per exception or ERET commit; ERET returns to the
    // EPC value held before the commit edge.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_flush_valid  <= 1'b0;
            r_flush_target <= 32'd0;
        end else if (exception_valid) begin
            r_flush_valid  <= 1'b1;
            r_flush_target <= EXCEPTION_VECTOR;
        end else if (eret_flush) begin
            r_flush_valid  <= 1'b1;
            r_flush_target <= r_epc;
        end else begin
            r_flush_valid  <= 1'b0;
            r_flush_target <= r_flush_target;
        end
    end

endmodule

// File: doc/cp0_exception_controller.md
Name: cp0_exception_controller

Overview:
- Owns the CP0 register set (BadVAddr, Count, Compare, Status, Cause, EPC) and sequences precise exceptions and ERET for the 5-stage MIPS core.
- Consumes the write-back stage's CP0 commit (MTC0 write, exception and ERET info) and serves MFC0 reads.
- Produces a registered one-cycle pipeline flush with redirect target, plus a combinational interrupt-pending flag that the decode stage tags onto the next instruction.

Parameters:
- EXCEPTION_VECTOR, 32'hBFC0_0380, flush target for all exceptions and interrupts.
- STATUS_BEV_RESET, 1'b1, read-only Status.BEV value.

Ports:
- clock  in  1  core clock
- reset_n  in  1  synchronous, active-low reset
- cp0_write_enabled  in  1  MTC0 commit from WB
- cp0_address_register  in  5  MTC0/MFC0 register number (rd)
- cp0_address_select  in  3  MTC0/MFC0 select (sel)
- cp0_write_data  in  32  MTC0 data
- exception_valid  in  1  WB commits an exception (includes interrupt, code 0)
- eret_flush  in  1  WB commits ERET
- in_delay_slot  in  1  faulting instruction is in a branch delay slot
- exception_code  in  5  ExcCode
- exception_address  in  32  PC of faulting instruction
- is_address_fault  in  1  BadVAddr must be written
- badvaddr_value  in  32  faulting virtual address
- read_data  out  32  MFC0 data for (cp0_address_register, cp0_address_select), combinational
- hardware_interrupt  in  6  external interrupt lines, level sensitive
- interrupt_pending  out  1  Status.IE & ~Status.EXL & |(Cause.IP & Status.IM)
- flush_valid  out  1  flush all stages, one-cycle pulse
- flush_target  out  32  redirect PC, valid with flush_valid

Behaviour:
- Reset (reset_n low at clock edge):
  - Status = {9'b0, STATUS_BEV_RESET, 22'b0}; Cause = 0; EPC = 0; BadVAddr = 0; Count = 0; Compare = 0; tick = 0.
  - flush_valid = 0, flush_target = 0, interrupt_pending = 0.
- Register map (sel 0 only):
  - 8 = BadVAddr (read-only)
  - 9 = Count
  - 11 = Compare
  - 12 = Status
  - 13 = Cause
  - 14 = EPC
  - Any other register or sel≠0 reads 0; writes to it are ignored.
- Writable bits: Status IM[15:8], EXL[1], IE[0]; Cause IP[9:8]; Count, Compare, EPC all 32 bits. All other bits are read-only.
- Commit priority in one cycle: exception_valid > eret_flush > cp0_write_enabled. The lower-priority action is dropped, not deferred.
- Exception commit:
  - If Status.EXL == 0: EPC = in_delay_slot ? exception_address − 4 (mod 2^32) : exception_address; Cause.BD = in_delay_slot.
  - If Status.EXL == 1: EPC and BD are unchanged.
  - Always: EXL = 1; Cause.ExcCode = exception_code.
  - BadVAddr = badvaddr_value iff is_address_fault.
  - Next cycle: flush_valid = 1, flush_target = EXCEPTION_VECTOR.
- ERET commit: EXL = 0. Next cycle: flush_valid = 1, flush_target = the EPC value before this edge.
- flush_valid is high for exactly one cycle per commit. Back-to-back commits give back-to-back pulses.
- Timer:
  - tick toggles every cycle; Count increments (wrapping at 2^32) on cycles where tick == 1.
  - An MTC0 to Count loads the data and clears tick.
  - Cause.TI (bit 30) sets on the edge where the updated Count equals Compare.
  - An MTC0 to Compare clears TI. If set-TI and write-Compare occur in the same cycle, the write wins.
- Cause.IP:
  - IP[7] = hardware_interrupt[5] | TI.
  - IP[6:2] = hardware_interrupt[4:0], registered each cycle (one-cycle sample latency).
  - IP[1:0] are software writable.
- interrupt_pending is combinational from the registered Status and Cause values.
- MFC0 read in the same cycle as an MTC0 to the same register returns the old value (no bypass).

Test Plan:
- Reset held 3 cycles, then released → read Status = 32'h0040_0000; all other registers 0; flush_valid 0.
- Exception: code 5'h04, exception_address 32'hBFC0_1004, in_delay_slot 1, is_address_fault 1, badvaddr 32'h0000_0003 → next cycle flush_valid 1, flush_target 32'hBFC0_0380; EPC 32'hBFC0_1000; Cause = 32'h8000_0010; BadVAddr 32'h3; Status.EXL 1.
- Second exception with EXL = 1, exception_address 32'hBFC0_2000 → EPC unchanged; flush pulses again. Then ERET → EXL 0; flush_target 32'hBFC0_1000.
- MTC0 Compare = 4, MTC0 Count = 0, Status = 32'h0000_8001 → TI sets at cycle 8 after the Count write; interrupt_pending 1. Then MTC0 Compare → TI 0, interrupt_pending 0.
- Same-cycle exception_valid + eret_flush + MTC0 EPC = 32'h1234 → exception wins, EPC is not 32'h1234, one flush to the vector.
- hardware_interrupt[2] = 1 with IM[4] and IE set → Cause.IP[4] reads 1 one cycle later; interrupt_pending 1. Then set EXL → interrupt_pending 0. Then assert reset_n low mid-stream → all state returns to reset values.
